udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path of the network block (udp_tx_request / udp_tx_length / udp_tx_data / port_ID) among NUM_REQ independent packet sources, e.g. DDC IQ streams, mic/status and the high-priority command reply.
- Grants one source per packet using round-robin order.
- Latches that source's length and port ID for the packet and multiplexes its byte stream.
- Holds off the next grant until the network finishes the frame and an inter-packet gap has elapsed.
- Runs entirely in the tx_clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GAP_CYCLES, 12: idle tx_clock cycles after a frame ends before the next request may be raised.
- TIMEOUT_CYCLES, 65535: maximum cycles to wait for udp_tx_enable after raising udp_tx_request before the grant is aborted.

Ports:
- clock, input, 1: tx_clock domain.
- reset, input, 1: asynchronous, active-high.
- req, input, NUM_REQ: per-source packet-ready level. Held until the source's done pulse.
- req_length, input, 16*NUM_REQ: per-source UDP payload length. Slice i is bits [16i+15:16i].
- req_data, input, 8*NUM_REQ: per-source payload byte.
- req_port_id, input, 8*NUM_REQ: per-source port_ID.
- udp_tx_enable, input, 1: network start/data strobe for the current UDP frame.
- udp_tx_active, input, 1: network UDP sender busy.
- udp_tx_request, output, 1: request to the network.
- udp_tx_length, output, 16: latched length of the granted source.
- udp_tx_data, output, 8: byte from the granted source.
- port_ID, output, 8: latched port ID of the granted source.
- grant, output, NUM_REQ: one-hot current owner.
- data_strobe, output, NUM_REQ: advance-byte strobe to the owner.
- done, output, NUM_REQ: one-cycle pulse to the owner at frame end.
- timeout, output, 1: one-cycle pulse on abort.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr = 0.
  - grant, data_strobe, done = 0.
  - udp_tx_request = 0; timeout = 0.
  - udp_tx_length = 0; port_ID = 0.
- udp_tx_data is combinational. It is req_data slice of the granted index, or 8'h00 when grant == 0.
- data_strobe[i] = grant[i] && udp_tx_enable (combinational).
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …).
  - On the next edge: set grant, latch udp_tx_length and port_ID from that slice, load the timeout counter, and go to REQUEST.
- REQUEST:
  - udp_tx_request = 1.
  - If udp_tx_enable is high, go to SEND.
  - Otherwise decrement the counter. At 0:
    - Pulse timeout and clear grant.
    - Set rr_ptr to selected+1 (mod NUM_REQ).
    - Go to GAP. No done pulse is issued.
- SEND:
  - udp_tx_request = 0.
  - Wait for udp_tx_active to be seen high, then low (falling edge detected in registers).
  - On the fall:
    - Pulse done[owner] for one cycle and clear grant on the same edge.
    - Set rr_ptr to owner+1, wrapping to 0 after NUM_REQ-1.
    - Load the gap counter with GAP_CYCLES and go to GAP.
- GAP:
  - Decrement the counter.
  - Go to IDLE on the cycle the counter reaches 0.
  - req is ignored in this state.
- Latency: from req rising in IDLE with no contention, grant is registered after 1 edge and udp_tx_request rises on that same edge.
- Length and port_ID stay stable from grant until the next grant. Later changes to a requester's req_length do not affect the frame in flight.
- A requester dropping req while granted does not abort the frame. The frame completes with whatever data that source drives.
- Simultaneous requests: exactly one grant, chosen by round-robin order. The other requests stay pending.
- Minimum spacing between two frames: GAP_CYCLES + 2 cycles after udp_tx_active falls.
- Asynchronous reset mid-packet: all outputs go to their reset values immediately and udp_tx_request drops. The network's own reset handles the partial frame.
- Widths: the counters are 16-bit. GAP_CYCLES = 0 means one cycle in GAP.

Optional Feature:
- Macro: UDP_ARB_STRICT_PRIO_EN.
- Defined: requester 0 has strict priority. When req[0] is set in IDLE it is granted regardless of rr_ptr. Requesters 1..NUM_REQ-1 round-robin among themselves, with rr_ptr cycling only over 1..NUM_REQ-1.
- Undefined: all requesters are round-robin as described in Behaviour.

Test Plan:
- Single request: req = 4'b0100, length 16'd1444, port_ID 8'd3.
  - grant = 4'b0100 and udp_tx_request = 1 next cycle.
  - udp_tx_length = 1444, port_ID = 3.
  - Network model raises udp_tx_enable, holds udp_tx_active 1450 cycles, then drops it → done[2] pulses once, then 12 gap cycles.
- All four req held high continuously → grant order 0, 1, 2, 3, 0. Each frame separated by at least 14 cycles after udp_tx_active falls.
- Data mux: grant = 1, req_data slice 1 = 8'hA5 with udp_tx_enable high → udp_tx_data = 8'hA5, data_strobe = 4'b0010, other strobes 0.
- Timeout: req[1] set, network never asserts udp_tx_enable → timeout pulses at 65535 cycles, grant clears, no done pulse, rr_ptr = 2.
- Reset asserted during SEND → udp_tx_request, grant, length and port_ID all 0 asynchronously. After release, IDLE re-grants from index 0.
- With UDP_ARB_STRICT_PRIO_EN defined: req = 4'b1111 held → grants 0, 0, 0, …. Dropping req[0] → 1, 2, 3, 1.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_arbiter
// Description : Round-robin arbiter sharing the single UDP transmit path of
//               the network block among NUM_REQ packet sources. One source is
//               granted per frame, its length/port_ID are latched, its byte
//               stream is multiplexed, and the next grant is held off until
//               the frame ends and an inter-packet gap has elapsed.
// Options     : UDP_ARB_STRICT_PRIO_EN - requester 0 wins whenever it asks;
//               requesters 1..NUM_REQ-1 round-robin among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_length,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [8*NUM_REQ-1:0]   req_port_id,
  input  logic                   udp_tx_enable,
  input  logic                   udp_tx_active,
  output logic                   udp_tx_request,
  output logic [15:0]            udp_tx_length,
  output logic [7:0]             udp_tx_data,
  output logic [7:0]             port_ID,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     data_strobe,
  output logic [NUM_REQ-1:0]     done,
  output logic                   timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef UDP_ARB_STRICT_PRIO_EN
  // Requester 0 sits outside the rotation; the pointer cycles over 1..N-1.
  localparam int c_first = 1;
`else
  localparam int c_first = 0;
`endif

  localparam int               c_scan_n    = NUM_REQ - c_first;
  localparam logic [IDX_W:0]   c_num_req   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W:0]   c_wrap      = (IDX_W+1)'(NUM_REQ - c_first);
  localparam logic [IDX_W-1:0] c_first_idx = IDX_W'(c_first);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] c_one_idx   = IDX_W'(1);
  localparam logic [15:0]      c_gap       = 16'(GAP_CYCLES);
  localparam logic [15:0]      c_timeout   = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SEND    = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [15:0]        r_cnt;
  logic               r_active_q;
  logic               r_active_seen;

  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_base;
  logic [IDX_W:0]     w_scan;
  logic [NUM_REQ-1:0] w_onehot;
  logic [15:0]        w_sel_len;
  logic [7:0]         w_sel_port;
  logic [IDX_W-1:0]   w_next_ptr;

  // Pick the first pending requester at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_base  = (r_rr_ptr == '0) ? c_first_idx : r_rr_ptr;
    w_scan  = '0;
    for (int k = 0; k < c_scan_n; k++) begin
      w_scan = {1'b0, w_base} + (IDX_W+1)'(k);
      if (w_scan >= c_num_req) begin
        w_scan = w_scan - c_wrap;
      end
      if (!w_found && req[w_scan[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_scan[IDX_W-1:0];
      end
    end
`ifdef UDP_ARB_STRICT_PRIO_EN
    if (req[0]) begin
      w_found = 1'b1;
      w_sel   = '0;
    end
`endif
  end

  // Decode the selected index into a one-hot grant and its length/port slices.
  always_comb begin
    w_onehot   = '0;
    w_sel_len  = 16'h0000;
    w_sel_port = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_len   = req_length[16*i +: 16];
        w_sel_port  = req_port_id[8*i +: 8];
      end
    end
  end

  // Pointer value after the current owner's turn ends (frame done or abort).
  always_comb begin
    if (r_owner == c_last_idx) begin
      w_next_ptr = c_first_idx;
    end else begin
      w_next_ptr = r_owner + c_one_idx;
    end
`ifdef UDP_ARB_STRICT_PRIO_EN
    if (r_owner == '0) begin
      w_next_ptr = r_rr_ptr;
    end
`endif
  end

  // Byte stream of the current owner; zero while nobody owns the path.
  always_comb begin
    udp_tx_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        udp_tx_data = req_data[8*i +: 8];
      end
    end
  end

  assign data_strobe = grant & {NUM_REQ{udp_tx_enable}};

  // Grant FSM: IDLE -> REQUEST -> SEND -> GAP, with abort from REQUEST to GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_cnt          <= 16'h0000;
      r_active_q     <= 1'b0;
      r_active_seen  <= 1'b0;
      grant          <= '0;
      done           <= '0;
      timeout        <= 1'b0;
      udp_tx_request <= 1'b0;
      udp_tx_length  <= 16'h0000;
      port_ID        <= 8'h00;
    end else begin
      done       <= '0;
      timeout    <= 1'b0;
      // Registered copy of the busy flag; frame end is its registered fall.
      r_active_q <= udp_tx_active;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            grant          <= w_onehot;
            r_owner        <= w_sel;
            udp_tx_length  <= w_sel_len;
            port_ID        <= w_sel_port;
            r_cnt          <= c_timeout;
            udp_tx_request <= 1'b1;
            r_state        <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (udp_tx_enable) begin
            udp_tx_request <= 1'b0;
            r_active_seen  <= 1'b0;
            r_state        <= ST_SEND;
          end else if (r_cnt <= 16'd1) begin
            // Network never answered: give up this turn without a done pulse.
            timeout        <= 1'b1;
            grant          <= '0;
            udp_tx_request <= 1'b0;
            r_rr_ptr       <= w_next_ptr;
            r_cnt          <= c_gap;
            r_state        <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_SEND: begin
          if (r_active_q) begin
            r_active_seen <= 1'b1;
          end else if (r_active_seen) begin
            done     <= grant;
            grant    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= c_gap;
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          // A count of 0 or 1 both leave after this single cycle.
          if (r_cnt <= 16'd1) begin
            r_cnt   <= 16'h0000;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_arbiter
// Description : Directed, self-checking bench for udp_tx_arbiter with a small
//               network model (enable/active handshake) and a data-mux table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 12;
  localparam int TMO = 65535;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [16*N-1:0] req_length;
  logic [8*N-1:0] req_data;
  logic [8*N-1:0] req_port_id;
  logic           udp_tx_enable = 1'b0;
  logic           udp_tx_active = 1'b0;
  logic           udp_tx_request;
  logic [15:0]    udp_tx_length;
  logic [7:0]     udp_tx_data;
  logic [7:0]     port_ID;
  logic [N-1:0]   grant;
  logic [N-1:0]   data_strobe;
  logic [N-1:0]   done;
  logic           timeout;

  int  checks   = 0;
  int  failures = 0;
  time fall_t   = 0;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [7:0]  exp_data;
    logic [3:0]  exp_strobe;
  } mux_vec_t;

  mux_vec_t vec [5];

  always #5 clock = ~clock;

  udp_tx_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .req_length     (req_length),
    .req_data       (req_data),
    .req_port_id    (req_port_id),
    .udp_tx_enable  (udp_tx_enable),
    .udp_tx_active  (udp_tx_active),
    .udp_tx_request (udp_tx_request),
    .udp_tx_length  (udp_tx_length),
    .udp_tx_data    (udp_tx_data),
    .port_ID        (port_ID),
    .grant          (grant),
    .data_strobe    (data_strobe),
    .done           (done),
    .timeout        (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (udp_tx_request !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_req_wait"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done === '0 && n < 10) begin
      cyc();
      n++;
    end
    check({name, "_done_wait"}, 32'(n < 10), 32'd1);
  endtask

  // One complete frame through the network model, default length/port slices.
  task automatic frame(input string name, input logic [N-1:0] exp_g, input int idx, input int act_len);
    wait_req(name);
    if (fall_t != 0) begin
      check({name, "_spacing"}, 32'(($time - fall_t) >= (GAP + 2) * 10), 32'd1);
    end
    check({name, "_grant"}, 32'(grant), 32'(exp_g));
    check({name, "_len"}, 32'(udp_tx_length), 32'(100 + idx));
    check({name, "_port"}, 32'(port_ID), 32'(10 + idx));
    udp_tx_enable = 1'b1;
    udp_tx_active = 1'b1;
    repeat (act_len) cyc();
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b0;
    fall_t = $time;
    wait_done(name);
    check({name, "_done"}, 32'(done), 32'(exp_g));
    check({name, "_grant_clr"}, 32'(grant), 32'd0);
    cyc();
    check({name, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int dn;

    vec[0] = '{32'h1122A533, 1'b1, 8'hA5, 4'b0010};
    vec[1] = '{32'h11225A33, 1'b0, 8'h5A, 4'b0000};
    vec[2] = '{32'hFFFF00FF, 1'b1, 8'h00, 4'b0010};
    vec[3] = '{32'h00003C00, 1'b1, 8'h3C, 4'b0010};
    vec[4] = '{32'hC3C3C3C3, 1'b0, 8'hC3, 4'b0000};

    for (int i = 0; i < N; i++) begin
      req_length[16*i +: 16] = 16'(100 + i);
      req_port_id[8*i +: 8]  = 8'(10 + i);
      req_data[8*i +: 8]     = 8'(8'h10 + i);
    end

    // Reset values
    repeat (2) cyc();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_request", 32'(udp_tx_request), 32'd0);
    check("rst_len", 32'(udp_tx_length), 32'd0);
    check("rst_port", 32'(port_ID), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_data", 32'(udp_tx_data), 32'd0);
    check("rst_strobe", 32'(data_strobe), 32'd0);
    reset = 1'b0;
    cyc();

`ifdef UDP_ARB_STRICT_PRIO_EN
    // Requester 0 always wins; the others rotate over 1..3
    req = 4'b1111;
    frame("sp0", 4'b0001, 0, 4);
    frame("sp1", 4'b0001, 0, 4);
    frame("sp2", 4'b0001, 0, 4);
    req = 4'b1110;
    frame("sp3", 4'b0010, 1, 4);
    frame("sp4", 4'b0100, 2, 4);
    frame("sp5", 4'b1000, 3, 4);
    frame("sp6", 4'b0010, 1, 4);
    req = '0;
`else
    // All four held high: rotation 0,1,2,3,0
    req = 4'b1111;
    frame("rr0", 4'b0001, 0, 4);
    frame("rr1", 4'b0010, 1, 4);
    frame("rr2", 4'b0100, 2, 4);
    frame("rr3", 4'b1000, 3, 4);
    frame("rr4", 4'b0001, 0, 4);
    req = '0;
`endif

    // Single request, long frame, one-edge grant latency
    repeat (20) cyc();
    req_length[47:32] = 16'd1444;
    req_port_id[23:16] = 8'd3;
    req = 4'b0100;
    cyc();
    check("a_grant", 32'(grant), 32'b0100);
    check("a_request", 32'(udp_tx_request), 32'd1);
    check("a_len", 32'(udp_tx_length), 32'd1444);
    check("a_port", 32'(port_ID), 32'd3);
    req_length[47:32] = 16'd9999;
    udp_tx_enable = 1'b1;
    udp_tx_active = 1'b1;
    cyc();
    check("a_req_drop", 32'(udp_tx_request), 32'd0);
    check("a_strobe", 32'(data_strobe), 32'b0100);
    req = '0;
    dn = 0;
    for (int i = 0; i < 1449; i++) begin
      cyc();
      if (done !== '0) dn++;
    end
    check("a_no_early_done", 32'(dn), 32'd0);
    check("a_len_hold", 32'(udp_tx_length), 32'd1444);
    check("a_grant_hold", 32'(grant), 32'b0100);
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b0;
    wait_done("a");
    check("a_done", 32'(done), 32'b0100);
    check("a_grant_clr", 32'(grant), 32'd0);

    // 12 gap cycles plus one idle cycle before the next grant is visible
    req = 4'b0010;
    n = 0;
    while (grant === '0 && n < 50) begin
      cyc();
      n++;
    end
    check("a_gap_len", 32'(n), 32'(GAP + 1));
    check("b_grant", 32'(grant), 32'b0010);

    // Data mux table while requester 1 owns the path
    udp_tx_enable = 1'b1;
    udp_tx_active = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req_data = vec[i].data;
      udp_tx_enable = vec[i].en;
      #1;
      check($sformatf("mux%0d_data", i), 32'(udp_tx_data), 32'(vec[i].exp_data));
      check($sformatf("mux%0d_strobe", i), 32'(data_strobe), 32'(vec[i].exp_strobe));
      cyc();
    end
    check("b_len", 32'(udp_tx_length), 32'd101);
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b0;
    wait_done("b");
    check("b_done", 32'(done), 32'b0010);

    // Timeout: requester 1 asks, network never answers
    n = 0;
    while (grant === '0 && n < 50) begin
      cyc();
      n++;
    end
    check("t_grant", 32'(grant), 32'b0010);
    n = 0;
    dn = 0;
    while (timeout !== 1'b1 && n < 70000) begin
      cyc();
      n++;
      if (done !== '0) dn++;
    end
    check("t_cycles", 32'(n), 32'(TMO));
    check("t_grant_clr", 32'(grant), 32'd0);
    check("t_request_clr", 32'(udp_tx_request), 32'd0);
    check("t_no_done", 32'(dn), 32'd0);
    req = '0;
    cyc();
    check("t_pulse_once", 32'(timeout), 32'd0);
    // Pointer moved past requester 1, so 2 is next among 1,2,3
    req = 4'b1110;
    n = 0;
    while (grant === '0 && n < 50) begin
      cyc();
      n++;
    end
    check("t_next_grant", 32'(grant), 32'b0100);

    // Asynchronous reset in the middle of a frame
    udp_tx_enable = 1'b1;
    udp_tx_active = 1'b1;
    repeat (4) cyc();
    #2;
    reset = 1'b1;
    #1;
    check("r_request", 32'(udp_tx_request), 32'd0);
    check("r_grant", 32'(grant), 32'd0);
    check("r_len", 32'(udp_tx_length), 32'd0);
    check("r_port", 32'(port_ID), 32'd0);
    cyc();
    reset = 1'b0;
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b0;
    req = 4'b1001;
    cyc();
    check("r_regrant", 32'(grant), 32'b0001);
    check("r_regrant_req", 32'(udp_tx_request), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
